// File: rtl/branch_unit_bht.sv
// Branch decision unit: resolves four branch conditions in EX, registers the PC-select and
// mispredict flush, and maintains a 2-bit saturating-counter BHT for fetch prediction.
module branch_unit_bht #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned IDX_W    = 4,
    parameter logic [1:0]  INIT_CTR = 2'b01,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             ex_valid,
    input  logic             branch,
    input  logic [1:0]       btype,
    input  logic             z,
    input  logic             n,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred,
    output logic             sel5,
    output logic             flush,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int Entries = int'(2 ** IDX_W);

    logic [1:0]       bht_q [Entries];
    logic             sel5_q, sel5_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] f_idx, ex_idx;
    logic             cond, resolve, taken;
    logic [1:0]       ctr_cur, ctr_nxt;

    // PCs are word-aligned; only the index bits take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0],
                              ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    assign f_idx  = f_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Read port has no bypass: a same-index write becomes visible the following cycle.
    assign f_pred_taken = bht_q[f_idx][1];

    always_comb begin
        cond = 1'b0;
        unique case (btype)
            2'b00: cond = z;
            2'b01: cond = ~z;
            2'b10: cond = n;
            2'b11: cond = ~n;
            default: cond = 1'b0;
        endcase
    end

    assign resolve = ex_valid & branch;
    assign taken   = resolve & cond;
    assign ctr_cur = bht_q[ex_idx];

    always_comb begin
        ctr_nxt = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
        end
    end

    always_comb begin
        sel5_d  = taken;
        flush_d = resolve & (taken ^ ex_pred);
        cnt_d   = cnt_q;
        if (flush_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel5_q  <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < Entries; i++) begin
                bht_q[i] <= INIT_CTR;
            end
        end else begin
            sel5_q  <= sel5_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            if (resolve) bht_q[ex_idx] <= ctr_nxt;
        end
    end

    assign sel5        = sel5_q;
    assign flush       = flush_q;
    assign mispred_cnt = cnt_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed self-checking bench for branch_unit_bht (CNT_W=4 to reach saturation quickly).
module tb_branch_unit_bht;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             clk_en;
    logic             rst;
    logic [PC_W-1:0]  f_pc;
    logic             f_pred_taken;
    logic             ex_valid;
    logic             branch;
    logic [1:0]       btype;
    logic             z;
    logic             n;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_pred;
    logic             sel5;
    logic             flush;
    logic [CNT_W-1:0] mispred_cnt;

    int n_checks;
    int n_errors;
    int exp_cnt;
    logic [1:0] ctr0;
    logic exp_taken;

    branch_unit_bht #(
        .PC_W    (PC_W),
        .IDX_W   (4),
        .INIT_CTR(2'b01),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_pc        (f_pc),
        .f_pred_taken(f_pred_taken),
        .ex_valid    (ex_valid),
        .branch      (branch),
        .btype       (btype),
        .z           (z),
        .n           (n),
        .ex_pc       (ex_pc),
        .ex_pred     (ex_pred),
        .sel5        (sel5),
        .flush       (flush),
        .mispred_cnt (mispred_cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_br(input logic [1:0] bt, input logic zz, input logic nn,
                            input logic [31:0] pc, input logic pred);
        ex_valid = 1'b1;
        branch   = 1'b1;
        btype    = bt;
        z        = zz;
        n        = nn;
        ex_pc    = pc;
        ex_pred  = pred;
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0;
        branch   = 1'b0;
        btype    = 2'b00;
        z        = 1'b0;
        n        = 1'b0;
        ex_pred  = 1'b0;
    endtask

    function automatic int sat_inc(input int v);
        return (v < 15) ? v + 1 : 15;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        rst      = 1'b0;
        f_pc     = '0;
        ex_pc    = '0;
        drive_idle();

        // Async reset with the clock idle
        #3 rst = 1'b1;
        #1;
        check_val("rst_sel5", 32'(sel5), 32'd0);
        check_val("rst_flush", 32'(flush), 32'd0);
        check_val("rst_cnt", 32'(mispred_cnt), 32'd0);
        for (int i = 0; i < 16; i++) begin
            f_pc = 32'(i * 4);
            #1;
            check_val($sformatf("rst_pred_%0d", i), 32'(f_pred_taken), 32'd0);
        end
        rst    = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);

        // Condition decode, back-to-back resolves at index 15
        for (int bt = 0; bt < 4; bt++) begin
            for (int zn = 0; zn < 4; zn++) begin
                drive_br(2'(bt), zn[1], zn[0], 32'h3C, 1'b0);
                case (bt)
                    0: exp_taken = zn[1];
                    1: exp_taken = ~zn[1];
                    2: exp_taken = zn[0];
                    default: exp_taken = ~zn[0];
                endcase
                @(negedge clk);
                if (exp_taken) exp_cnt = sat_inc(exp_cnt);
                check_val($sformatf("dec_sel5_b%0d_zn%0d", bt, zn), 32'(sel5), 32'(exp_taken));
                check_val($sformatf("dec_flush_b%0d_zn%0d", bt, zn), 32'(flush), 32'(exp_taken));
                check_val($sformatf("dec_cnt_b%0d_zn%0d", bt, zn), 32'(mispred_cnt), 32'(exp_cnt));
            end
        end

        // Counter saturation at index 0
        f_pc = 32'h40;
        ctr0 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            drive_br(2'b00, 1'b1, 1'b0, 32'h40, 1'b0);
            @(negedge clk);
            if (ctr0 != 2'b11) ctr0 = ctr0 + 2'd1;
            exp_cnt = sat_inc(exp_cnt);
            check_val($sformatf("sat_up_pred_%0d", i), 32'(f_pred_taken), 32'(ctr0[1]));
            check_val($sformatf("sat_up_flush_%0d", i), 32'(flush), 32'd1);
            check_val($sformatf("sat_up_cnt_%0d", i), 32'(mispred_cnt), 32'(exp_cnt));
        end
        for (int i = 0; i < 5; i++) begin
            drive_br(2'b00, 1'b0, 1'b0, 32'h40, 1'b0);
            @(negedge clk);
            if (ctr0 != 2'b00) ctr0 = ctr0 - 2'd1;
            check_val($sformatf("sat_dn_pred_%0d", i), 32'(f_pred_taken), 32'(ctr0[1]));
            check_val($sformatf("sat_dn_sel5_%0d", i), 32'(sel5), 32'd0);
            check_val($sformatf("sat_dn_flush_%0d", i), 32'(flush), 32'd0);
        end

        // Gating at index 1 (counter 1: a spurious taken update would flip the prediction)
        f_pc = 32'h44;
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 3; i++) begin
                drive_br(2'b00, 1'b1, 1'b0, 32'h44, 1'b0);
                if (mode == 0) ex_valid = 1'b0;
                else branch = 1'b0;
                @(negedge clk);
                check_val($sformatf("gate_sel5_m%0d_%0d", mode, i), 32'(sel5), 32'd0);
                check_val($sformatf("gate_flush_m%0d_%0d", mode, i), 32'(flush), 32'd0);
                check_val($sformatf("gate_pred_m%0d_%0d", mode, i), 32'(f_pred_taken), 32'd0);
                check_val($sformatf("gate_cnt_m%0d_%0d", mode, i), 32'(mispred_cnt),
                          32'(exp_cnt));
            end
        end

        // Same-index conflict: bring index 0 to 1, then resolve a taken branch from an alias
        drive_br(2'b00, 1'b1, 1'b0, 32'h40, 1'b1);
        @(negedge clk);
        check_val("conf_setup_pred", 32'(f_pred_taken), 32'd0);
        f_pc = 32'h80;
        drive_br(2'b00, 1'b1, 1'b0, 32'h80, 1'b1);
        #1;
        check_val("conf_pred_during", 32'(f_pred_taken), 32'd0);
        @(negedge clk);
        check_val("conf_pred_after", 32'(f_pred_taken), 32'd1);
        check_val("conf_sel5", 32'(sel5), 32'd1);
        check_val("conf_flush", 32'(flush), 32'd0);
        check_val("conf_cnt", 32'(mispred_cnt), 32'(exp_cnt));

        // Mid-cycle reset with the clock running
        drive_idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("mrst_cnt", 32'(mispred_cnt), 32'd0);
        check_val("mrst_pred", 32'(f_pred_taken), 32'd0);
        rst     = 1'b0;
        exp_cnt = 0;
        @(negedge clk);

        // Mispredict counter saturation
        for (int i = 0; i < 17; i++) begin
            drive_br(2'b01, 1'b0, 1'b0, 32'h3C, 1'b0);
            @(negedge clk);
            exp_cnt = sat_inc(exp_cnt);
            check_val($sformatf("mis_flush_%0d", i), 32'(flush), 32'd1);
            check_val($sformatf("mis_cnt_%0d", i), 32'(mispred_cnt), 32'(exp_cnt));
        end
        check_val("mis_cnt_final", 32'(mispred_cnt), 32'd15);
        #2 rst = 1'b1;
        #1;
        check_val("fin_rst_cnt", 32'(mispred_cnt), 32'd0);
        check_val("fin_rst_flush", 32'(flush), 32'd0);
        check_val("fin_rst_sel5", 32'(sel5), 32'd0);
        rst = 1'b0;
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
